alu_issue: RTL and testbench

Issue/collect stage that sits directly upstream of the CPU's ALU instance. It accepts one operation at a time from the control unit over a valid/ready handshake and drives the ALU's operand, opcode and start inputs from registers. It runs the multi-cycle DIV start/finished protocol, including a timeout, and returns result, high word, flags and a destination tag over a second valid/ready handshake. It lets the control unit treat every ALU operation, single-cycle or multi-cycle, uniformly.

---
 rtl/alu_issue.sv | 191 +++++++++++++++++++
 tb/tb_alu_issue.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// -----------------------------------------------------------------------------
// alu_issue
//
// Issue/collect stage sitting directly in front of the CPU's ALU. It accepts
// one operation at a time from the control unit, drives the ALU operand,
// opcode and start inputs from registers, runs the multi-cycle DIV
// start/finished protocol with a timeout, and returns the result, high word,
// flags and destination tag over a response handshake. Every ALU operation,
// single-cycle or multi-cycle, therefore looks the same to the control unit.
//
// Ports
//   CLK, RESET_N           clock (posedge) and asynchronous active-low reset
//   req_valid/req_ready    request handshake; req_ready is combinational and
//                          is high only in IDLE while reset is released
//   req_a, req_b, req_op   operands and opcode (1=ADD .. 10=SHR, 3=MUL, 4=DIV)
//   req_tag                destination tag, returned unchanged on rsp_tag
//   alu_a, alu_b           registered operands to the ALU
//   alu_opcode             registered opcode to the ALU
//   alu_start              registered one-cycle DIV start pulse
//   alu_result, alu_high   ALU outputs (ALU updates them on negedge)
//   alu_flags              ALU flags {POSITIVE, OVERFLOW, CARRY, ZERO}
//   alu_finished           ALU multi-cycle completion
//   rsp_valid/rsp_ready    response handshake
//   rsp_result, rsp_high   captured result and high word
//   rsp_flags, rsp_tag     captured flags and request tag
//   rsp_err                illegal opcode, divide by zero or DIV timeout
// -----------------------------------------------------------------------------
module alu_issue #(
  parameter int N            = 16,
  parameter int ALU_OP_COUNT = 4,
  parameter int FLAGS_COUNT  = 4,
  parameter int TAG_W        = 4,
  parameter int DIV_TIMEOUT  = 64
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  // request side
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [N-1:0]            req_a,
  input  logic [N-1:0]            req_b,
  input  logic [ALU_OP_COUNT-1:0] req_op,
  input  logic [TAG_W-1:0]        req_tag,
  // ALU side
  output logic [N-1:0]            alu_a,
  output logic [N-1:0]            alu_b,
  output logic [ALU_OP_COUNT-1:0] alu_opcode,
  output logic                    alu_start,
  input  logic [N-1:0]            alu_result,
  input  logic [N-1:0]            alu_high,
  input  logic [FLAGS_COUNT-1:0]  alu_flags,
  input  logic                    alu_finished,
  // response side
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [N-1:0]            rsp_result,
  output logic [N-1:0]            rsp_high,
  output logic [FLAGS_COUNT-1:0]  rsp_flags,
  output logic [TAG_W-1:0]        rsp_tag,
  output logic                    rsp_err
);

  // Counter must be able to hold DIV_TIMEOUT itself.
  localparam int CNT_W = $clog2(DIV_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_COUNT = CNT_W'(DIV_TIMEOUT);

  localparam logic [ALU_OP_COUNT-1:0] OP_FIRST = ALU_OP_COUNT'(1);
  localparam logic [ALU_OP_COUNT-1:0] OP_LAST  = ALU_OP_COUNT'(10);
  localparam logic [ALU_OP_COUNT-1:0] OP_DIV   = ALU_OP_COUNT'(4);

  typedef enum logic [2:0] {
    IDLE,
    EXEC,
    DIV_START,
    DIV_WAIT,
    RESP
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_count;
  logic [CNT_W-1:0] wait_count_inc;
  logic             op_legal;
  logic             div_by_zero;
  logic             req_fault;

  // Gated with RESET_N so that nothing is accepted while reset is held.
  assign req_ready = (state == IDLE) && RESET_N;

  // Faulted requests never reach the ALU and are answered directly.
  assign op_legal       = (req_op >= OP_FIRST) && (req_op <= OP_LAST);
  assign div_by_zero    = (req_op == OP_DIV) && (req_b == '0);
  assign req_fault      = !op_legal || div_by_zero;
  assign wait_count_inc = wait_count + CNT_W'(1);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= IDLE;
      wait_count <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      alu_start  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_high   <= '0;
      rsp_flags  <= '0;
      rsp_tag    <= '0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // req_ready is high here, so req_valid alone completes the handshake.
          if (req_valid) begin
            rsp_tag <= req_tag;
            if (req_fault) begin
              // ALU inputs are left untouched; answer with an error at once.
              rsp_result <= '0;
              rsp_high   <= '0;
              rsp_flags  <= '0;
              rsp_err    <= 1'b1;
              rsp_valid  <= 1'b1;
              state      <= RESP;
            end else begin
              alu_a      <= req_a;
              alu_b      <= req_b;
              alu_opcode <= req_op;
              if (req_op == OP_DIV) begin
                alu_start  <= 1'b1;
                wait_count <= '0;
                state      <= DIV_START;
              end else begin
                state <= EXEC;
              end
            end
          end
        end

        EXEC: begin
          // ALU evaluated on the preceding negedge; its outputs are settled.
          rsp_result <= alu_result;
          rsp_high   <= alu_high;
          rsp_flags  <= alu_flags;
          rsp_err    <= 1'b0;
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end

        DIV_START: begin
          alu_start <= 1'b0;
          state     <= DIV_WAIT;
        end

        DIV_WAIT: begin
          if (alu_finished) begin
            rsp_result <= alu_result;   // quotient
            rsp_high   <= alu_high;     // remainder
            rsp_flags  <= alu_flags;
            rsp_err    <= 1'b0;
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end else begin
            wait_count <= wait_count_inc;
            // The DIV_TIMEOUT-th unfinished sample ends the wait.
            if (wait_count_inc == TIMEOUT_COUNT) begin
              rsp_result <= '0;
              rsp_high   <= '0;
              rsp_flags  <= '0;
              rsp_err    <= 1'b1;
              rsp_valid  <= 1'b1;
              state      <= RESP;
            end
          end
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          alu_start <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
module tb_alu_issue;

  localparam int N   = 16;
  localparam int OPW = 4;
  localparam int FW  = 4;
  localparam int TW  = 4;
  localparam int TMO = 8;

  logic           CLK = 1'b0;
  logic           RESET_N;
  logic           req_valid;
  logic           req_ready;
  logic [N-1:0]   req_a;
  logic [N-1:0]   req_b;
  logic [OPW-1:0] req_op;
  logic [TW-1:0]  req_tag;
  logic [N-1:0]   alu_a;
  logic [N-1:0]   alu_b;
  logic [OPW-1:0] alu_opcode;
  logic           alu_start;
  logic [N-1:0]   alu_result = '0;
  logic [N-1:0]   alu_high = '0;
  logic [FW-1:0]  alu_flags = '0;
  logic           alu_finished = 1'b0;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [N-1:0]   rsp_result;
  logic [N-1:0]   rsp_high;
  logic [FW-1:0]  rsp_flags;
  logic [TW-1:0]  rsp_tag;
  logic           rsp_err;

  int checks = 0;
  int errors = 0;
  int start_cycles = 0;
  int busy = 0;
  int div_lat = 1;
  bit div_hang = 1'b0;

  always #5 CLK = ~CLK;

  alu_issue #(
    .N(N), .ALU_OP_COUNT(OPW), .FLAGS_COUNT(FW), .TAG_W(TW), .DIV_TIMEOUT(TMO)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_tag(req_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_start(alu_start),
    .alu_result(alu_result), .alu_high(alu_high), .alu_flags(alu_flags),
    .alu_finished(alu_finished),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_high(rsp_high), .rsp_flags(rsp_flags),
    .rsp_tag(rsp_tag), .rsp_err(rsp_err)
  );

  // Arithmetic of the ALU: returns {flags, high, result};
  // flags = {POSITIVE, OVERFLOW, CARRY, ZERO}.
  function automatic logic [FW+2*N-1:0] alu_fn(input logic [OPW-1:0] op,
                                                input logic [N-1:0] a,
                                                input logic [N-1:0] b);
    logic [N:0]     w;
    logic [2*N-1:0] p;
    logic [N-1:0]   r;
    logic [N-1:0]   h;
    logic           c;
    logic           v;
    w = '0; p = '0; r = '0; h = '0; c = 1'b0; v = 1'b0;
    case (op)
      4'd1: begin
        w = {1'b0, a} + {1'b0, b}; r = w[N-1:0]; c = w[N];
        v = (a[N-1] == b[N-1]) && (r[N-1] != a[N-1]);
      end
      4'd2: begin
        w = {1'b0, a} - {1'b0, b}; r = w[N-1:0]; c = w[N];
        v = (a[N-1] != b[N-1]) && (r[N-1] != a[N-1]);
      end
      4'd3: begin
        p = {{N{1'b0}}, a} * {{N{1'b0}}, b};
        r = p[N-1:0]; h = p[2*N-1:N]; c = (h != '0);
      end
      4'd4: if (b != '0) begin r = a / b; h = a % b; end
      4'd5: r = a & b;
      4'd6: r = a | b;
      4'd7: r = a ^ b;
      4'd8: r = ~a;
      4'd9: r = a << b[3:0];
      4'd10: r = a >> b[3:0];
      default: ;
    endcase
    return {(~r[N-1]) && (r != '0), v, c, (r == '0), h, r};
  endfunction

  // Behavioural ALU: combinational ops settle on negedge; DIV raises
  // alu_finished div_lat negedges after it sees alu_start (never if div_hang).
  always @(negedge CLK) begin
    if (alu_start) begin
      busy <= div_lat;
      alu_finished <= 1'b0;
    end else if (busy > 0) begin
      busy <= busy - 1;
      if (busy == 1 && !div_hang) begin
        alu_finished <= 1'b1;
        {alu_flags, alu_high, alu_result} <= alu_fn(alu_opcode, alu_a, alu_b);
      end
    end
    if (alu_opcode != 4'd4)
      {alu_flags, alu_high, alu_result} <= alu_fn(alu_opcode, alu_a, alu_b);
  end

  always @(negedge CLK)
    if (alu_start) start_cycles <= start_cycles + 1;

  // Expected response: err/result/high/flags and number of edges after
  // acceptance until rsp_valid is seen.
  task automatic ref_model(input logic [OPW-1:0] op, input logic [N-1:0] a,
                           input logic [N-1:0] b, input int lat, input bit hang,
                           output logic e, output logic [N-1:0] r,
                           output logic [N-1:0] h, output logic [FW-1:0] f,
                           output int l);
    if (op < 4'd1 || op > 4'd10 || (op == 4'd4 && b == '0)) begin
      e = 1'b1; r = '0; h = '0; f = '0; l = 1;
    end else if (op == 4'd4 && hang) begin
      e = 1'b1; r = '0; h = '0; f = '0; l = 1 + TMO;
    end else begin
      e = 1'b0;
      {f, h, r} = alu_fn(op, a, b);
      l = (op == 4'd4) ? lat + 1 : 1;
    end
  endtask

  // Drive one request from IDLE, wait (bounded) for the response, capture it
  // and complete the response handshake. obs_lat = -1 if none arrived.
  task automatic issue(input logic [OPW-1:0] op, input logic [N-1:0] a,
                       input logic [N-1:0] b, input logic [TW-1:0] tag,
                       input int lat, input bit hang, output int obs_lat,
                       output logic [N-1:0] r, output logic [N-1:0] h,
                       output logic [FW-1:0] f, output logic [TW-1:0] t,
                       output logic e);
    div_lat = lat;
    div_hang = hang;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_tag = tag;
    @(posedge CLK); #1;
    req_valid = 1'b0;
    obs_lat = -1;
    for (int n = 1; n <= 40 && obs_lat < 0; n++) begin
      @(posedge CLK); #1;
      if (rsp_valid) obs_lat = n;
    end
    r = rsp_result; h = rsp_high; f = rsp_flags; t = rsp_tag; e = rsp_err;
    rsp_ready = 1'b1;
    @(posedge CLK); #1;
    rsp_ready = 1'b0;
    $display("txn op=%0d a=%h b=%h tag=%0d lat=%0d -> res=%h high=%h flags=%b tag=%0d err=%0d",
             op, a, b, tag, obs_lat, r, h, f, t, e);
  endtask

  task automatic test_reset;
    RESET_N = 1'b0;
    req_valid = 1'b0; rsp_ready = 1'b0;
    req_a = '0; req_b = '0; req_op = '0; req_tag = '0;
    @(posedge CLK); #1;
    checks++;
    if ({req_ready, rsp_valid, alu_start, rsp_err, alu_a, alu_b, alu_opcode,
         rsp_result, rsp_high, rsp_flags, rsp_tag} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%b v=%b st=%b err=%b a=%h b=%h op=%h res=%h hi=%h fl=%h tag=%h want all 0",
               req_ready, rsp_valid, alu_start, rsp_err, alu_a, alu_b, alu_opcode,
               rsp_result, rsp_high, rsp_flags, rsp_tag);
    end
    @(negedge CLK);
    RESET_N = 1'b1;
    @(posedge CLK); #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready got %b want 1", req_ready);
    end
  endtask

  task automatic test_add_mul;
    int ol; logic [N-1:0] r, h; logic [FW-1:0] f; logic [TW-1:0] t; logic e;
    issue(4'd1, 16'h7FFF, 16'h0001, 4'd3, 1, 1'b0, ol, r, h, f, t, e);
    checks++;
    if (ol !== 1) begin errors++; $display("FAIL add_latency got %0d want 1", ol); end
    checks++;
    if ({e, r, f, t} !== {1'b0, 16'h8000, 4'b0100, 4'd3}) begin
      errors++;
      $display("FAIL add_rsp got err=%b res=%h fl=%b tag=%0d want err=0 res=8000 fl=0100 tag=3", e, r, f, t);
    end
    issue(4'd3, 16'h1234, 16'h0100, 4'd7, 1, 1'b0, ol, r, h, f, t, e);
    checks++;
    if ({ol == 1, e, r, h, t} !== {1'b1, 1'b0, 16'h3400, 16'h0012, 4'd7}) begin
      errors++;
      $display("FAIL mul_rsp got lat=%0d err=%b res=%h hi=%h tag=%0d want lat=1 err=0 res=3400 hi=0012 tag=7",
               ol, e, r, h, t);
    end
  endtask

  task automatic test_div;
    int ol, s0; logic [N-1:0] r, h; logic [FW-1:0] f; logic [TW-1:0] t; logic e;
    s0 = start_cycles;
    issue(4'd4, 16'd100, 16'd7, 4'd6, 3, 1'b0, ol, r, h, f, t, e);
    checks++;
    if (ol !== 4) begin errors++; $display("FAIL div_latency got %0d want 4", ol); end
    checks++;
    if ({e, r, h, t} !== {1'b0, 16'd14, 16'd2, 4'd6}) begin
      errors++;
      $display("FAIL div_rsp got err=%b q=%0d r=%0d tag=%0d want err=0 q=14 r=2 tag=6", e, r, h, t);
    end
    checks++;
    if (start_cycles - s0 !== 1) begin
      errors++; $display("FAIL div_start_cycles got %0d want 1", start_cycles - s0);
    end
  endtask

  task automatic test_errors;
    int ol, s0; logic [N-1:0] r, h; logic [FW-1:0] f; logic [TW-1:0] t; logic e;
    logic [OPW-1:0] bad_ops [3];
    bad_ops[0] = 4'd4; bad_ops[1] = 4'd0; bad_ops[2] = 4'd15;
    issue(4'd5, 16'h00FF, 16'h0F0F, 4'd8, 1, 1'b0, ol, r, h, f, t, e);
    checks++;
    if ({e, r} !== {1'b0, 16'h000F}) begin
      errors++; $display("FAIL and_rsp got err=%b res=%h want err=0 res=000f", e, r);
    end
    s0 = start_cycles;
    for (int i = 0; i < 3; i++) begin
      issue(bad_ops[i], 16'd5, 16'd0, 4'(i + 1), 1, 1'b0, ol, r, h, f, t, e);
      checks++;
      if ({ol == 1, e, r, h, f, t} !== {1'b1, 1'b1, 16'h0, 16'h0, 4'h0, 4'(i + 1)}) begin
        errors++;
        $display("FAIL err_rsp op=%0d got lat=%0d err=%b res=%h hi=%h fl=%b tag=%0d want lat=1 err=1 zeros tag=%0d",
                 bad_ops[i], ol, e, r, h, f, t, i + 1);
      end
      checks++;
      if ({alu_opcode, alu_b} !== {4'd5, 16'h0F0F}) begin
        errors++;
        $display("FAIL err_alu_held got op=%0d b=%h want op=5 b=0f0f", alu_opcode, alu_b);
      end
    end
    checks++;
    if (start_cycles - s0 !== 0) begin
      errors++; $display("FAIL err_no_start got %0d want 0", start_cycles - s0);
    end
  endtask

  task automatic test_timeout;
    int ol, s0; logic [N-1:0] r, h; logic [FW-1:0] f; logic [TW-1:0] t; logic e;
    s0 = start_cycles;
    issue(4'd4, 16'd50, 16'd3, 4'd2, 3, 1'b1, ol, r, h, f, t, e);
    checks++;
    if (ol !== TMO + 1) begin
      errors++; $display("FAIL timeout_latency got %0d want %0d", ol, TMO + 1);
    end
    checks++;
    if ({e, r, h, f, t} !== {1'b1, 16'h0, 16'h0, 4'h0, 4'd2}) begin
      errors++;
      $display("FAIL timeout_rsp got err=%b res=%h hi=%h fl=%b tag=%0d want err=1 zeros tag=2", e, r, h, f, t);
    end
    checks++;
    if (start_cycles - s0 !== 1) begin
      errors++; $display("FAIL timeout_start got %0d want 1", start_cycles - s0);
    end
  endtask

  task automatic test_backpressure;
    div_hang = 1'b0;
    req_valid = 1'b1; req_op = 4'd1; req_a = 16'h1111; req_b = 16'h2222; req_tag = 4'd5;
    @(posedge CLK); #1;
    req_a = 16'h0F0F; req_b = 16'h0101; req_tag = 4'd9;   // held, must wait
    @(posedge CLK); #1;
    checks++;
    if ({rsp_valid, rsp_result, rsp_flags, rsp_tag, rsp_err} !== {1'b1, 16'h3333, 4'b1000, 4'd5, 1'b0}) begin
      errors++;
      $display("FAIL bp_first got v=%b res=%h fl=%b tag=%0d err=%b want v=1 res=3333 fl=1000 tag=5 err=0",
               rsp_valid, rsp_result, rsp_flags, rsp_tag, rsp_err);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK); #1;
      checks++;
      if ({rsp_valid, rsp_result, rsp_flags, rsp_tag, rsp_err, req_ready} !==
          {1'b1, 16'h3333, 4'b1000, 4'd5, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL bp_stable cycle=%0d got v=%b res=%h fl=%b tag=%0d err=%b rdy=%b want held response, rdy=0",
                 i, rsp_valid, rsp_result, rsp_flags, rsp_tag, rsp_err, req_ready);
      end
    end
    rsp_ready = 1'b1;
    @(posedge CLK); #1;                   // response handshake edge
    rsp_ready = 1'b0;
    checks++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      errors++; $display("FAIL bp_handshake got v=%b rdy=%b want v=0 rdy=1", rsp_valid, req_ready);
    end
    @(posedge CLK); #1;                   // held ADD accepted here
    req_valid = 1'b0;
    @(posedge CLK); #1;
    checks++;
    if ({rsp_valid, rsp_result, rsp_tag, rsp_err} !== {1'b1, 16'h1010, 4'd9, 1'b0}) begin
      errors++;
      $display("FAIL bp_second got v=%b res=%h tag=%0d err=%b want v=1 res=1010 tag=9 err=0",
               rsp_valid, rsp_result, rsp_tag, rsp_err);
    end
    rsp_ready = 1'b1;
    @(posedge CLK); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_div;
    int ol; logic [N-1:0] r, h; logic [FW-1:0] f; logic [TW-1:0] t; logic e;
    div_lat = 6; div_hang = 1'b0;
    req_valid = 1'b1; req_op = 4'd4; req_a = 16'd1000; req_b = 16'd3; req_tag = 4'd11;
    @(posedge CLK); #1;
    req_valid = 1'b0;
    @(posedge CLK);
    @(posedge CLK); #3;                   // now waiting on the divider
    RESET_N = 1'b0;
    #1;
    checks++;
    if ({req_ready, rsp_valid, alu_start, rsp_err, alu_a, alu_b, alu_opcode,
         rsp_result, rsp_high, rsp_flags, rsp_tag} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs got rdy=%b v=%b st=%b err=%b a=%h b=%h op=%h res=%h tag=%h want all 0",
               req_ready, rsp_valid, alu_start, rsp_err, alu_a, alu_b, alu_opcode, rsp_result, rsp_tag);
    end
    @(negedge CLK);
    RESET_N = 1'b1;
    @(posedge CLK); #1;
    issue(4'd2, 16'd3, 16'd5, 4'd4, 1, 1'b0, ol, r, h, f, t, e);
    checks++;
    if ({ol == 1, e, r, f[3], t} !== {1'b1, 1'b0, 16'hFFFE, 1'b0, 4'd4}) begin
      errors++;
      $display("FAIL sub_after_reset got lat=%0d err=%b res=%h pos=%b tag=%0d want lat=1 err=0 res=fffe pos=0 tag=4",
               ol, e, r, f[3], t);
    end
  endtask

  task automatic test_back_to_back;
    int ready_cycles, valid_cycles;
    ready_cycles = 0; valid_cycles = 0;
    req_valid = 1'b1; rsp_ready = 1'b1; req_op = 4'd1;
    req_a = 16'($urandom); req_b = 16'($urandom); req_tag = 4'd1;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      if (req_ready) ready_cycles++;
      if (rsp_valid) valid_cycles++;
    end
    @(posedge CLK); #1;
    req_valid = 1'b0; rsp_ready = 1'b0;
    checks++;
    if ({ready_cycles, valid_cycles} !== {32'd4, 32'd4}) begin
      errors++;
      $display("FAIL back_to_back got accepts=%0d responses=%0d in 12 cycles want 4 and 4",
               ready_cycles, valid_cycles);
    end
  endtask

  task automatic test_random;
    int ol, el, lat; logic [N-1:0] r, h, er, eh, a, b; logic [FW-1:0] f, ef;
    logic [TW-1:0] t, tag; logic e, ee; logic [OPW-1:0] op; bit hang;
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      a = 16'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      tag = 4'($urandom);
      lat = $urandom_range(1, 6);
      hang = (op == 4'd4) && ($urandom_range(0, 5) == 0);
      ref_model(op, a, b, lat, hang, ee, er, eh, ef, el);
      issue(op, a, b, tag, lat, hang, ol, r, h, f, t, e);
      checks++;
      if (ol !== el) begin
        errors++; $display("FAIL rand_latency i=%0d op=%0d got %0d want %0d", i, op, ol, el);
      end
      checks++;
      if ({e, r, f, t} !== {ee, er, ef, tag}) begin
        errors++;
        $display("FAIL rand_rsp i=%0d op=%0d a=%h b=%h got err=%b res=%h fl=%b tag=%0d want err=%b res=%h fl=%b tag=%0d",
                 i, op, a, b, e, r, f, t, ee, er, ef, tag);
      end
      if (op == 4'd3 || op == 4'd4 || ee) begin
        checks++;
        if (h !== eh) begin
          errors++; $display("FAIL rand_high i=%0d op=%0d got %h want %h", i, op, h, eh);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_mul();
    test_div();
    test_errors();
    test_timeout();
    test_backpressure();
    test_reset_mid_div();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
